// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Optional ack watchdog and mem_err output are enabled with `define MEM_TIMEOUT_EN.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
`ifdef MEM_TIMEOUT_EN
    output logic                mem_err,
`endif
    output logic                busy
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StBusyIf,
        StBusyDm
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          starve_q, starve_d;
    logic                drop_q, drop_d;
    logic                drop_now;
    logic                if_elig;

    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
    logic [WdW-1:0]      wd_q, wd_d;
    logic                err_q, err_d;
`endif

    assign if_elig = if_req & ~if_flush;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        drop_d      = drop_q;
        drop_now    = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rvalid_d = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
`ifdef MEM_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                // Data wins ties until fetch has lost STARVE_MAX rounds in a row.
                if (if_elig && (!dm_req || starve_q == StarveMax)) begin
                    if_gnt = 1'b1;
                end else if (dm_req) begin
                    dm_gnt = 1'b1;
                end

                if (if_gnt) begin
                    state_d     = StBusyIf;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    starve_d    = 4'd0;
                    drop_d      = 1'b0;
                end else if (dm_gnt) begin
                    state_d     = StBusyDm;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_be;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    if (if_elig && starve_q < StarveMax) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                wd_d = '0;
`endif
            end

            StBusyIf, StBusyDm: begin
                // A flush in the ack cycle must suppress the response too.
                drop_now = drop_q | ((state_q == StBusyIf) & if_flush);
                if (state_q == StBusyIf) begin
                    drop_d = drop_now;
                end

                if (mem_ack) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    if (state_q == StBusyIf) begin
                        if_rvalid_d = ~drop_now;
                        if_rdata_d  = mem_rdata;
                    end else begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = mem_rdata;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (wd_q == WdW'(TIMEOUT_CYC - 1)) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == StBusyIf) begin
                        if_rvalid_d = ~drop_now;
                        if_rdata_d  = '0;
                    end else begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = '0;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            starve_q    <= 4'd0;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rvalid_q <= 1'b0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rvalid_q <= dm_rvalid_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rvalid = dm_rvalid_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: plays both requesters and the memory,
// and checks every cycle against a transaction-level reference model.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;

    logic              clk;
    logic              rst_n;
    logic              if_req, if_flush, if_gnt, if_rvalid;
    logic [31:0]       if_addr, if_rdata;
    logic              dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [3:0]        dm_be;
    logic [31:0]       dm_addr, dm_wdata, dm_rdata;
    logic              mem_req, mem_we, mem_ack;
    logic [3:0]        mem_be;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;
    logic              busy;

    int n_cmp = 0;
    int n_mis = 0;

    // Requester bookkeeping
    bit if_pend, dm_pend;

    // Reference model: owner 0 = none, 1 = fetch, 2 = data
    int          m_owner;
    int          m_starve;
    bit          m_drop;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    bit          m_if_rv, m_dm_rv;
    logic [31:0] m_if_rd, m_dm_rd;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_be    (dm_be),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_gnt   (dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata (dm_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit chance(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic model_reset();
        m_owner  = 0;
        m_starve = 0;
        m_drop   = 0;
        m_we     = 0;
        m_be     = '0;
        m_addr   = '0;
        m_wdata  = '0;
        m_if_rv  = 0;
        m_dm_rv  = 0;
        m_if_rd  = '0;
        m_dm_rd  = '0;
        if_pend  = 0;
        dm_pend  = 0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, ".busy"},      busy,      0);
        check_eq({pfx, ".mem_req"},   mem_req,   0);
        check_eq({pfx, ".mem_we"},    mem_we,    0);
        check_eq({pfx, ".mem_be"},    mem_be,    0);
        check_eq({pfx, ".mem_addr"},  mem_addr,  0);
        check_eq({pfx, ".mem_wdata"}, mem_wdata, 0);
        check_eq({pfx, ".if_gnt"},    if_gnt,    0);
        check_eq({pfx, ".dm_gnt"},    dm_gnt,    0);
        check_eq({pfx, ".if_rvalid"}, if_rvalid, 0);
        check_eq({pfx, ".dm_rvalid"}, dm_rvalid, 0);
        check_eq({pfx, ".if_rdata"},  if_rdata,  0);
        check_eq({pfx, ".dm_rdata"},  dm_rdata,  0);
    endtask

    // One clock: drive stimulus after the edge, check and advance the model mid-cycle.
    task automatic run_cycle(input int p_if, input int p_dm, input int p_ack, input int p_flush);
        bit e_if, e_dm, fetch_ok, n_if_rv, n_dm_rv, dropped;
        @(posedge clk);
        #1;
        if (!if_pend && chance(p_if)) begin
            if_pend = 1;
            if_addr = $urandom;
        end
        if_req   = if_pend;
        if_flush = chance(p_flush);
        if (!dm_pend && chance(p_dm)) begin
            dm_pend  = 1;
            dm_we    = 1'($urandom);
            dm_be    = 4'($urandom);
            dm_addr  = $urandom;
            dm_wdata = $urandom;
        end
        dm_req    = dm_pend;
        mem_ack   = (m_owner != 0) && chance(p_ack);
        mem_rdata = $urandom;

        @(negedge clk);
        fetch_ok = if_req && !if_flush;
        e_if = (m_owner == 0) && fetch_ok && (!dm_req || m_starve == STARVE_MAX);
        e_dm = (m_owner == 0) && dm_req && !e_if;

        check_eq("busy", busy, m_owner != 0);
        check_eq("mem_req", mem_req, m_owner != 0);
        check_eq("if_gnt", if_gnt, e_if);
        check_eq("dm_gnt", dm_gnt, e_dm);
        check_eq("if_rvalid", if_rvalid, m_if_rv);
        check_eq("dm_rvalid", dm_rvalid, m_dm_rv);
        if (m_if_rv) check_eq("if_rdata", if_rdata, m_if_rd);
        if (m_dm_rv) check_eq("dm_rdata", dm_rdata, m_dm_rd);
        if (m_owner != 0) begin
            check_eq("mem_we", mem_we, m_we);
            check_eq("mem_be", mem_be, m_be);
            check_eq("mem_addr", mem_addr, m_addr);
            if (m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
        end

        n_if_rv = 0;
        n_dm_rv = 0;
        if (m_owner == 0) begin
            if (e_if) begin
                m_owner  = 1;
                m_we     = 0;
                m_be     = 4'hF;
                m_addr   = if_addr;
                m_starve = 0;
                m_drop   = 0;
                if_pend  = 0;
            end else if (e_dm) begin
                m_owner = 2;
                m_we    = dm_we;
                m_be    = dm_be;
                m_addr  = dm_addr;
                m_wdata = dm_wdata;
                if (fetch_ok && m_starve < STARVE_MAX) m_starve = m_starve + 1;
                dm_pend = 0;
            end
        end else begin
            dropped = m_drop || (m_owner == 1 && if_flush);
            if (m_owner == 1) m_drop = dropped;
            if (mem_ack) begin
                if (m_owner == 1) begin
                    n_if_rv = !dropped;
                    m_if_rd = mem_rdata;
                end else begin
                    n_dm_rv = 1;
                    m_dm_rd = mem_rdata;
                end
                m_owner = 0;
                m_drop  = 0;
            end
        end
        m_if_rv = n_if_rv;
        m_dm_rv = n_dm_rv;
    endtask

    initial begin
        rst_n     = 1'b0;
        if_req    = 0;
        if_addr   = '0;
        if_flush  = 0;
        dm_req    = 0;
        dm_we     = 0;
        dm_be     = '0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_ack   = 0;
        mem_rdata = '0;
        model_reset();

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Mixed traffic with occasional flushes and slow memory
        repeat (300) run_cycle(50, 50, 50, 10);
        // Both requesters saturated: exercises the starvation guard
        repeat (60) run_cycle(100, 100, 100, 0);
        // Flush-heavy fetch traffic with delayed acks
        repeat (150) run_cycle(70, 20, 30, 30);

        // Drain, then reset while a data access is in flight
        repeat (15) run_cycle(0, 0, 100, 0);
        run_cycle(0, 100, 0, 0);
        run_cycle(0, 0, 0, 0);
        check_eq("midreset.pre_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (5) run_cycle(0, 0, 100, 0);

        repeat (200) run_cycle(60, 60, 60, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
